// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    ADDR     = ST_ADDR,
    ADDR_ACK = ST_ADDR_ACK,
    DATA     = ST_DATA,
    DATA_ACK = ST_DATA_ACK,
    IGNORE   = ST_IGNORE
  } i2c_tgt_state_t;

  localparam int   I2C_BYTE_BITS = 8;
  localparam logic I2C_RW_WRITE  = 1'b0;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA synchronizer, optional stability filter (I2C_GLITCH_FILT_EN) and
// START/STOP/SCL-edge detection on the conditioned bus view.
module i2c_line_cond
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NSYNC-1:0] scl_sync_q, sda_sync_q;
  logic             scl_f, sda_f;
  logic             scl_prev_q, sda_prev_q;

  // Idle bus is high, so reset to 1 to avoid a spurious event after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[NSYNC-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[NSYNC-2:0], sda_i};
    end
  end

`ifdef I2C_GLITCH_FILT_EN
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    raw;
  logic [1:0]    filt_q;
  logic [CW-1:0] cnt_q [2];

  assign raw = {sda_sync_q[NSYNC-1], scl_sync_q[NSYNC-1]};

  // Output follows the input only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '1;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
          filt_q[i] <= raw[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign {sda_f, scl_f} = filt_q;
`else
  // FILT_LEN has no effect without the filter.
  if (FILT_LEN >= 0) begin : g_pass
    assign scl_f = scl_sync_q[NSYNC-1];
    assign sda_f = sda_sync_q[NSYNC-1];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  assign sda_o      = sda_f;
  assign scl_rise_o = scl_f & ~scl_prev_q;
  assign scl_fall_o = ~scl_f & scl_prev_q;
  assign start_o    = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_o     = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: address match, ACK generation, byte strobes to fabric.
// Optional glitch filter enabled by defining I2C_GLITCH_FILT_EN.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h52,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_t,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  logic sda_lvl, scl_rise, scl_fall, start_ev, stop_ev;

  i2c_line_cond #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_line (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_lvl),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_ev),
    .stop_o    (stop_ev)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [6:0] shift_q, shift_d;
  logic [7:0] byte_in;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_t_q, sda_t_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic       busy_q, busy_d;
  logic       ack_drv_q, ack_drv_d;
  logic       first_pend_q, first_pend_d;
  logic       last_bit;

  assign byte_in  = {shift_q, sda_lvl};
  assign cnt_inc  = (cnt_q >= 4'(I2C_BYTE_BITS)) ? cnt_q : cnt_q + 4'd1;
  assign last_bit = (cnt_q == 4'(I2C_BYTE_BITS - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    sda_t_d      = sda_t_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = 1'b0;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;
    busy_d       = busy_q;
    ack_drv_d    = ack_drv_q;
    first_pend_d = first_pend_q;

    if (start_ev) begin
      state_d     = ADDR;
      cnt_d       = '0;
      sda_t_d     = 1'b1;
      ack_drv_d   = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_ev) begin
      state_d    = IDLE;
      cnt_d      = '0;
      sda_t_d    = 1'b1;
      ack_drv_d  = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_inc;
            if (last_bit) begin
              if (byte_in[7:1] == TARGET_ADDR && byte_in[0] == I2C_RW_WRITE) begin
                state_d      = ADDR_ACK;
                busy_d       = 1'b1;
                first_pend_d = 1'b1;
                ack_drv_d    = 1'b0;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
                sda_t_d = 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_inc;
            if (last_bit) begin
              rx_data_d    = byte_in;
              rx_valid_d   = 1'b1;
              rx_first_d   = first_pend_q;
              first_pend_d = 1'b0;
              ack_drv_d    = 1'b0;
              state_d      = DATA_ACK;
            end
          end
        end
        // First fall after the 8th rise starts the ACK, the next one ends it.
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_t_d   = 1'b0;
              ack_drv_d = 1'b1;
            end else begin
              sda_t_d   = 1'b1;
              ack_drv_d = 1'b0;
              cnt_d     = '0;
              state_d   = DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      sda_t_q      <= 1'b1;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      busy_q       <= 1'b0;
      ack_drv_q    <= 1'b0;
      first_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      sda_t_q      <= sda_t_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
      busy_q       <= busy_d;
      ack_drv_q    <= ack_drv_d;
      first_pend_q <= first_pend_d;
    end
  end

  assign sda_t     = sda_t_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_first  = rx_first_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged open-drain master, frame-level model,
// scoreboard of received bytes checked by an independent monitor.
module tb_i2c_target_rx;

  localparam int Q = 25;  // quarter of a 100-clk SCL period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_t;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, start_det, stop_det, busy;
  logic       sda_bus;

  assign sda_bus = sda_m & sda_t;

  i2c_target_rx dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_t    (sda_t),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .start_det(start_det),
    .stop_det (stop_det),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int start_cnt = 0, stop_cnt = 0;
  int exp_start = 0, exp_stop = 0;
  bit saw_drive = 1'b0;
  logic [8:0] exp_q [$];   // {first, data}
  logic [7:0] tx_buf [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: counts strobes and pops the scoreboard on each rx_valid.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (start_det) start_cnt++;
      if (stop_det) stop_cnt++;
      if (sda_t == 1'b0) saw_drive = 1'b1;
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected got=%0h exp=none", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e[7:0]));
          chk("rx_first", 32'(rx_first), 32'(e[8]));
        end
      end
    end
  end

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_cond();
    q_wait(); sda_m = 1'b0; q_wait(); scl_m = 1'b0; q_wait();
  endtask

  task automatic rep_start();
    sda_m = 1'b1; q_wait(); scl_m = 1'b1; q_wait(); sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; q_wait(); scl_m = 1'b1; q_wait(); sda_m = 1'b1; q_wait();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_m = b; q_wait(); scl_m = 1'b1; q_wait();
    if (glitch) begin
      @(negedge clk) scl_m = 1'b0;
      @(negedge clk) scl_m = 1'b1;
    end
    q_wait(); scl_m = 1'b0; q_wait();
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
    sda_m = 1'b1; q_wait(); scl_m = 1'b1; q_wait();
    ack = !sda_bus;
    q_wait(); scl_m = 1'b0; q_wait();
  endtask

  // end_kind: 0 = STOP, 1 = leave open for a repeated START, 2 = 4 bits then STOP
  task automatic run_frame(input int n, input bit rstart, input int end_kind);
    bit match, ack;
    saw_drive = 1'b0;
    if (rstart) rep_start(); else start_cond();
    exp_start++;
    match = (tx_buf[0][7:1] == 7'h52) && (tx_buf[0][0] == 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && match) exp_q.push_back({(i == 1), tx_buf[i]});
      send_byte(tx_buf[i], -1, ack);
      chk(i == 0 ? "addr_ack" : "data_ack", 32'(ack), 32'(match));
      if (i == 0) chk("busy_after_addr", 32'(busy), 32'(match));
    end
    if (end_kind == 2) begin
      for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
    end
    if (end_kind != 1) begin
      stop_cond();
      exp_stop++;
      q_wait();
      chk("busy_after_stop", 32'(busy), 32'd0);
      chk("sda_t_after_stop", 32'(sda_t), 32'd1);
    end
    chk("sda_driven", 32'(saw_drive), 32'(match && n >= 1));
    chk("start_count", 32'(start_cnt), 32'(exp_start));
    chk("stop_count", 32'(stop_cnt), 32'(exp_stop));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, n, ek, prev_end;
    bit ack;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_sda_t", 32'(sda_t), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({start_det, stop_det}), 32'd0);

    tx_buf[0] = 8'hA4; tx_buf[1] = 8'h3C;
    run_frame(2, 1'b0, 0);
    tx_buf[0] = 8'hA6; tx_buf[1] = 8'h55;
    run_frame(2, 1'b0, 0);
    tx_buf[0] = 8'hA5; tx_buf[1] = 8'h99;
    run_frame(2, 1'b0, 0);
    tx_buf[0] = 8'hA4; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    run_frame(4, 1'b0, 0);
    tx_buf[0] = 8'hA4; tx_buf[1] = 8'h11;
    run_frame(2, 1'b0, 1);
    tx_buf[0] = 8'hA4; tx_buf[1] = 8'h77;
    run_frame(2, 1'b1, 0);
    tx_buf[0] = 8'hA4;
    run_frame(1, 1'b0, 2);

`ifdef I2C_GLITCH_FILT_EN
    start_cond();
    exp_start++;
    send_byte(8'hA4, -1, ack);
    chk("glitch_addr_ack", 32'(ack), 32'd1);
    exp_q.push_back({1'b1, 8'h5A});
    send_byte(8'h5A, 3, ack);
    chk("glitch_data_ack", 32'(ack), 32'd1);
    stop_cond();
    exp_stop++;
    q_wait();
`endif

    // Reset in the middle of the address ACK.
    start_cond();
    exp_start++;
    for (int i = 7; i >= 0; i--) send_bit(tx_buf[0][i], 1'b0);
    sda_m = 1'b1; q_wait(); scl_m = 1'b1;
    repeat (5) @(negedge clk);
    chk("ack_before_rst", 32'(sda_t), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_sda_t", 32'(sda_t), 32'd1);
    chk("rst_async_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q_wait();
    chk("post_rst_sda_t", 32'(sda_t), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    prev_end = 0;
    for (int f = 0; f < 10; f++) begin
      sel = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      ek = (f == 9) ? 0 : $urandom_range(0, 2);
      tx_buf[0] = (sel == 0) ? 8'hA4 : (sel == 1) ? 8'hA6 : (sel == 2) ? 8'hA5 : 8'($urandom);
      for (int i = 1; i < n; i++) tx_buf[i] = 8'($urandom);
      run_frame(n, prev_end == 1, ek);
      prev_end = ek;
    end

    q_wait();
    chk("rx_missing", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
